// File: rtl/mil_rx_word_fifo.sv
`default_nettype none
// ============================================================================
//  mil_rx_word_fifo
//  Word buffer between the MIL-STD-1553 receiver push port and the host
//  readout. Each entry holds a 2-bit word type and a 16-bit data word.
//  Reports fill level, a sticky overflow flag and a saturating drop counter.
//  Revision: 1.0  initial release
// ============================================================================
module mil_rx_word_fifo #(
  parameter int DEPTH       = 16,
  parameter bit DROP_ERRORS = 1'b0,
  parameter int CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_request,
  input  logic [1:0]               in_type,
  input  logic [15:0]              in_word,
  output logic                     in_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_type,
  output logic [15:0]              out_word,
  input  logic                     flush,
  input  logic                     ovf_clear,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [1:0]  WERROR    = 2'b00;
  localparam logic [AW:0] LVL_FULL  = (AW+1)'(DEPTH);

  logic [17:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          is_err;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          drop;
  logic [AW-1:0] rd_ptr_nxt;
  logic [17:0]   head_nxt;
  logic [AW:0]   level_nxt;

  assign full = (level == LVL_FULL);

  // Accept/pop/drop decisions and the entry that becomes the head next cycle
  always_comb begin
    is_err     = DROP_ERRORS && (in_type == WERROR);
    push       = in_request & ~flush & ~is_err;
    pop        = out_valid & out_ready & ~flush;
    wr_en      = push & (~full | pop);
    drop       = push & full & ~pop;
    rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
    // The written slot only coincides with the next head when the FIFO
    // would otherwise be empty, so bypass the RAM for that case.
    head_nxt   = (wr_en && (wr_ptr == rd_ptr_nxt)) ? {in_type, in_word}
                                                   : mem[rd_ptr_nxt];
    case ({wr_en, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // Storage array; contents need no reset because level gates visibility
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {in_type, in_word};
    end
  end

  // Pointers, level, registered head and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      in_done   <= 1'b0;
      out_valid <= 1'b0;
      out_type  <= '0;
      out_word  <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      in_done <= wr_en;
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        level     <= '0;
        out_valid <= 1'b0;
        out_type  <= '0;
        out_word  <= '0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        rd_ptr    <= rd_ptr_nxt;
        level     <= level_nxt;
        out_valid <= (level_nxt != '0);
        if (level_nxt != '0) begin
          out_type <= head_nxt[17:16];
          out_word <= head_nxt[15:0];
        end else begin
          out_type <= '0;
          out_word <= '0;
        end
      end
      // A drop in the same cycle as ovf_clear wins and counts as the first loss
      if (drop) begin
        overflow <= 1'b1;
        if (ovf_clear) begin
          drop_cnt <= CNT_W'(1);
        end else if (drop_cnt != {CNT_W{1'b1}}) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end else if (ovf_clear) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mil_rx_word_fifo.sv
`default_nettype none
// ============================================================================
//  tb_mil_rx_word_fifo
//  Directed scenarios plus randomized traffic checked every cycle against a
//  queue-based reference model of the word FIFO (DEPTH=16, DROP_ERRORS=1).
//  Revision: 1.0  initial release
// ============================================================================
module tb_mil_rx_word_fifo;

  localparam int DEPTH = 16;
  localparam int CNT_W = 8;
  localparam logic [1:0] WERROR = 2'b00;
  localparam logic [1:0] WSERV  = 2'b01;
  localparam logic [1:0] WDATA  = 2'b10;

  logic        clk;
  logic        rst;
  logic        in_request;
  logic [1:0]  in_type;
  logic [15:0] in_word;
  logic        in_done;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_type;
  logic [15:0] out_word;
  logic        flush;
  logic        ovf_clear;
  logic [4:0]  level;
  logic        full;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [17:0] q[$];
  bit          m_ovf;
  int          m_cnt;
  bit          m_done;

  mil_rx_word_fifo #(.DEPTH(DEPTH), .DROP_ERRORS(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_request(in_request), .in_type(in_type), .in_word(in_word),
    .in_done(in_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_type(out_type), .out_word(out_word),
    .flush(flush), .ovf_clear(ovf_clear),
    .level(level), .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural rules of the FIFO applied to the queue model for one clock
  task automatic model_update(input bit req, input logic [1:0] ty, input logic [15:0] wd,
                              input bit rdy, input bit fl, input bit clr, input bit rs);
    bit pop, push, is_full, acc, drop;
    if (rs) begin
      q.delete();
      m_ovf  = 0;
      m_cnt  = 0;
      m_done = 0;
      return;
    end
    pop     = (q.size() > 0) && rdy && !fl;
    push    = req && !fl && (ty != WERROR);
    is_full = (q.size() == DEPTH);
    acc     = push && (!is_full || pop);
    drop    = push && is_full && !pop;
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back({ty, wd});
    end
    m_done = acc;
    if (drop) begin
      m_ovf = 1;
      m_cnt = clr ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
    end else if (clr) begin
      m_ovf = 0;
      m_cnt = 0;
    end
  endtask

  task automatic check_all();
    check("in_done",  32'(in_done),   32'(m_done));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_type", 32'(out_type), 32'(q[0][17:16]));
      check("out_word", 32'(out_word), 32'(q[0][15:0]));
    end
    check("level",    32'(level),    32'(q.size()));
    check("full",     32'(full),     32'(q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
  endtask

  // One clock: drive inputs, advance the model, compare after the edge
  task automatic step(input bit req, input logic [1:0] ty, input logic [15:0] wd,
                      input bit rdy, input bit fl, input bit clr, input bit rs);
    in_request = req;
    in_type    = ty;
    in_word    = wd;
    out_ready  = rdy;
    flush      = fl;
    ovf_clear  = clr;
    rst        = rs;
    model_update(req, ty, wd, rdy, fl, clr, rs);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input bit rdy);
    step(0, WERROR, 16'h0, rdy, 0, 0, 0);
  endtask

  initial begin
    in_request = 0; in_type = '0; in_word = '0; out_ready = 0;
    flush = 0; ovf_clear = 0; rst = 1;

    // Reset state
    step(0, WERROR, 16'h0, 0, 0, 0, 1);
    check("rst_out_word", 32'(out_word), 32'h0);
    check("rst_out_type", 32'(out_type), 32'h0);

    // Two words in order, visible one cycle after the first push
    step(1, WSERV, 16'hEFAB, 1, 0, 0, 0);
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_head",  32'(out_word),  32'hEFAB);
    step(1, WDATA, 16'h02A1, 1, 0, 0, 0);
    check("t1_head2", 32'(out_word), 32'h02A1);
    idle(1);
    idle(1);
    check("t1_level", 32'(level), 32'h0);

    // WERROR filtered out entirely
    step(0, WERROR, 16'h0, 0, 0, 0, 1);
    step(1, WERROR, 16'h1234, 0, 0, 0, 0);
    check("t4_done_err", 32'(in_done), 32'h0);
    step(1, WDATA, 16'h5678, 0, 0, 0, 0);
    check("t4_level", 32'(level), 32'h1);
    check("t4_word",  32'(out_word), 32'h5678);
    check("t4_ovf",   32'(overflow), 32'h0);

    // Fill to full, then three drops
    step(0, WERROR, 16'h0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, WDATA, 16'(i), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, WDATA, 16'(16 + i), 0, 0, 0, 0);
      check("t2_done_drop", 32'(in_done), 32'h0);
    end
    check("t2_full",  32'(full),     32'h1);
    check("t2_level", 32'(level),    32'h10);
    check("t2_cnt",   32'(drop_cnt), 32'h3);
    // Push and pop together while full: no drop
    step(1, WDATA, 16'h00AA, 1, 0, 0, 0);
    check("t3_level", 32'(level),    32'h10);
    check("t3_cnt",   32'(drop_cnt), 32'h3);
    check("t3_done",  32'(in_done),  32'h1);
    for (int i = 0; i < 17; i++) idle(1);

    // Five stored, flush with a simultaneous push
    for (int i = 0; i < 5; i++) step(1, WSERV, 16'(16'h100 + i), 0, 0, 0, 0);
    step(1, WDATA, 16'h0BAD, 0, 1, 0, 0);
    check("t5_level", 32'(level),     32'h0);
    check("t5_valid", 32'(out_valid), 32'h0);
    check("t5_cnt",   32'(drop_cnt),  32'h3);
    check("t5_ovf",   32'(overflow),  32'h1);
    step(0, WERROR, 16'h0, 0, 0, 1, 0);
    check("t5_clr_ovf", 32'(overflow), 32'h0);
    check("t5_clr_cnt", 32'(drop_cnt), 32'h0);

    // Drop together with ovf_clear: the drop wins
    for (int i = 0; i < 16; i++) step(1, WDATA, 16'(16'h200 + i), 0, 0, 0, 0);
    step(1, WDATA, 16'h0FFF, 0, 0, 1, 0);
    check("clr_drop_ovf", 32'(overflow), 32'h1);
    check("clr_drop_cnt", 32'(drop_cnt), 32'h1);

    // Continuous push and pop across pointer wrap, then reset mid-stream
    step(0, WERROR, 16'h0, 0, 1, 1, 0);
    for (int i = 0; i < 40; i++) step(1, WDATA, 16'(i), 1, 0, 0, 0);
    step(1, WDATA, 16'h7777, 1, 0, 0, 1);
    check("t6_rst_valid", 32'(out_valid), 32'h0);
    check("t6_rst_level", 32'(level),     32'h0);
    check("t6_rst_done",  32'(in_done),   32'h0);
    check("t6_rst_word",  32'(out_word),  32'h0);

    // Randomized traffic with alternating fill/drain pressure
    for (int i = 0; i < 3000; i++) begin
      int unsigned rdy_pct;
      rdy_pct = ((i / 200) % 2 == 0) ? 20 : 80;
      step($urandom_range(99) < 60,
           2'($urandom_range(3)),
           16'($urandom),
           $urandom_range(99) < rdy_pct,
           $urandom_range(99) < 2,
           $urandom_range(99) < 3,
           $urandom_range(999) < 5);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
